// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one beat-oriented memory port between an icache
// (line reads) and a dcache (line reads and writebacks), one burst at a time.
module mem_arbiter #(
    parameter int MEM_AW = 12,
    parameter int MEM_DW = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [MEM_AW-1:0] ic_req_addr,
    output logic              ic_rsp_valid,
    output logic [MEM_DW-1:0] ic_rsp_data,

    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [MEM_AW-1:0] dc_req_addr,
    input  logic              dc_req_we,
    input  logic [MEM_DW-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_rsp_valid,
    output logic [MEM_DW-1:0] dc_rsp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [MEM_AW-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [MEM_DW-1:0] mem_rsp_data,

    output logic              busy
);

    localparam int LB = $clog2(BEATS);
    localparam int CW = LB + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state, state_nxt;
    logic                owner_dc;
    logic                last_dc;
    logic                we;
    logic [MEM_AW-1:0]   base;
    logic [CW-1:0]       issue_cnt;
    logic [CW-1:0]       rsp_cnt;
    logic                grant_ic, grant_dc;
    logic                beat_fire, rsp_fire, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_dc  <= 1'b0;
            last_dc   <= 1'b0;
            we        <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            rsp_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ic || grant_dc) begin
                owner_dc  <= grant_dc;
                we        <= grant_dc && dc_req_we;
                base      <= (grant_dc ? dc_req_addr : ic_req_addr) & ~MEM_AW'(BEATS - 1);
                issue_cnt <= '0;
                rsp_cnt   <= '0;
            end else begin
                if (beat_fire) issue_cnt <= issue_cnt + CW'(1);
                if (rsp_fire)  rsp_cnt   <= rsp_cnt + CW'(1);
            end
            if (done) last_dc <= owner_dc;
        end
    end

    // Everything below is gated by rst so outputs are quiet during reset even
    // though the state register only clears on the following edge.
    always_comb begin
        state_nxt      = state;
        grant_ic       = 1'b0;
        grant_dc       = 1'b0;
        beat_fire      = 1'b0;
        rsp_fire       = 1'b0;
        done           = 1'b0;
        ic_req_ready   = 1'b0;
        dc_req_ready   = 1'b0;
        ic_rsp_valid   = 1'b0;
        dc_rsp_valid   = 1'b0;
        dc_wdata_ready = 1'b0;
        mem_req_valid  = 1'b0;
        busy           = 1'b0;
        ic_rsp_data    = mem_rsp_data;
        dc_rsp_data    = mem_rsp_data;
        mem_req_addr   = base | MEM_AW'(issue_cnt[LB-1:0]);
        mem_req_we     = we;
        mem_wdata      = dc_wdata;
        if (!rst) begin
            case (state)
                IDLE: begin
                    grant_dc     = dc_req_valid && (!ic_req_valid || !last_dc);
                    grant_ic     = ic_req_valid && !grant_dc;
                    ic_req_ready = grant_ic;
                    dc_req_ready = grant_dc;
                    if (grant_ic || grant_dc) state_nxt = XFER;
                end
                XFER: begin
                    busy           = 1'b1;
                    mem_req_valid  = issue_cnt < CW'(BEATS);
                    beat_fire      = mem_req_valid && mem_req_ready;
                    dc_wdata_ready = beat_fire && we;
                    rsp_fire       = mem_rsp_valid && !we;
                    ic_rsp_valid   = rsp_fire && !owner_dc;
                    dc_rsp_valid   = rsp_fire && owner_dc;
                    done = we ? (beat_fire && issue_cnt == CW'(BEATS - 1))
                              : (rsp_fire && rsp_cnt == CW'(BEATS - 1));
                    if (done) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
